// File: rtl/uart_tx_frame_if.sv
// Producer-side word handshake for uart_tx_frame: a word moves on a clock edge
// where in_valid && in_ready; data_in only matters on that edge.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output data_in, output in_valid, input in_ready);
  modport slave  (input data_in, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: idle-high line, low start bit, LSB-first data,
// optional even/odd parity and one or two stop bits, valid/ready word input.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_frame_if.slave s_if,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_MAX = BW'(STOP_BITS - 1);
  localparam logic          ODD      = (PARITY == 2);
  localparam logic          HAS_PAR  = (PARITY != 0);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [BW-1:0]         r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
  logic                  r_par, w_par_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_busy;
  logic                  r_done, w_done_nxt;
  logic                  w_last;

  assign w_last = (r_cnt == CNT_MAX);

  // r_bit indexes data bits in DATA and counts stop bits in STOP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_done_nxt  = 1'b0;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_last ? '0 : r_cnt + CW'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (s_if.in_valid) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_shift_nxt = s_if.data_in;
          w_par_nxt   = (^s_if.data_in) ^ ODD;
        end
      end
      S_START: begin
        if (w_last) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_MAX) begin
            w_bit_nxt   = '0;
            w_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_last) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
        end
      end
      S_STOP: begin
        if (w_last) begin
          if (r_bit == STOP_MAX) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the start bit appears on the accepting edge.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign s_if.in_ready = (r_state == S_IDLE);
  assign tx            = r_tx;
  assign busy          = r_busy;
  assign done          = r_done;
  assign o_dbg_state   = r_state;

endmodule
